adap_timer_axil_slave: RTL and testbench

AXI4-Lite responder holding the AdapTimer2 register file (four 32-bit read/write registers) and the down-counter they configure. It is the slave end of the S_AXI interface that the master BFM drives in the block-design bench. Written values read back unchanged. The timer block derives its count and interrupt from the registers.

---
 rtl/adap_timer_axil_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_adap_timer_axil_slave.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adap_timer_axil_slave.sv
// ---------------------------------------------------------------------------
// adap_timer_axil_slave
//
// AXI4-Lite responder for the AdapTimer2 register file, plus the down-counter
// that the registers configure.
//
// Register map (byte address, bits [3:2] select, bits [1:0] ignored):
//   0x0 LOAD     reload value for the counter
//   0x4 CTRL     bit0 enable, bit1 auto-reload, remaining bits storage only
//   0x8 SCRATCH0 storage only
//   0xC SCRATCH1 storage only
// Every register is fully read/write and reads back exactly as written.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock (rising edge), async active-low reset
//   S_AXI_AW*/W*/B*             write address, write data, write response
//   S_AXI_AR*/R*                read address, read data
//   timer_count                 current counter value
//   timer_irq                   one-cycle pulse when the counter reaches 0
// ---------------------------------------------------------------------------
module adap_timer_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   timer_count,
    output logic                            timer_irq
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [DW-1:0] ONE = DW'(1);

    localparam logic [1:0] IDX_LOAD = 2'd0;
    localparam logic [1:0] IDX_CTRL = 2'd1;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Register file
    logic [3:0][DW-1:0] regs_q, regs_d;

    // Write channel: address and data latches, each with its own flag
    logic              aw_flag_q, aw_flag_d;
    logic [1:0]        aw_idx_q,  aw_idx_d;
    logic              w_flag_q,  w_flag_d;
    logic [DW-1:0]     w_data_q,  w_data_d;
    logic [STRB_W-1:0] w_strb_q,  w_strb_d;
    logic              bvalid_q,  bvalid_d;

    // Read channel
    rd_state_e         rd_state_q, rd_state_d;
    logic [DW-1:0]     rdata_q,    rdata_d;

    // Timer
    logic [DW-1:0]     count_q,   count_d;
    logic              irq_q,     irq_d;
    logic              en_prev_q, en_prev_d;

    // Write-path helpers
    logic              aw_hs, w_hs;
    logic              aw_have, w_have;
    logic [1:0]        wr_idx;
    logic [DW-1:0]     wr_data;
    logic [STRB_W-1:0] wr_strb;

    // Timer helpers
    logic              tmr_en, tmr_auto;

    // PROT and the byte-offset address bits carry no meaning for this block.
    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = !aw_flag_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_flag_q  && !bvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;

    assign S_AXI_ARREADY = (rd_state_q == R_IDLE);
    assign S_AXI_RVALID  = (rd_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    assign timer_count   = count_q;
    assign timer_irq     = irq_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

    // -----------------------------------------------------------------------
    // Write channel and register file
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        regs_d    = regs_q;
        aw_flag_d = aw_flag_q;
        aw_idx_d  = aw_idx_q;
        w_flag_d  = w_flag_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;

        // A half that is already latched, or arriving this cycle, counts as
        // present; this lets a same-cycle AW+W commit on the handshake edge.
        aw_have = aw_flag_q || aw_hs;
        w_have  = w_flag_q  || w_hs;
        wr_idx  = aw_flag_q ? aw_idx_q : S_AXI_AWADDR[3:2];
        wr_data = w_flag_q  ? w_data_q : S_AXI_WDATA;
        wr_strb = w_flag_q  ? w_strb_q : S_AXI_WSTRB;

        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (aw_have && w_have) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    regs_d[wr_idx][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
            aw_flag_d = 1'b0;
            w_flag_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_flag_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_flag_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read channel: data is captured from regs_q on the accepting edge, so a
    // write committing on that same edge is not visible to this read.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rdata_d    = regs_q[S_AXI_ARADDR[3:2]];
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Timer: uses the committed LOAD/CTRL values, so a LOAD write only shows
    // up at the next reload and a CTRL write acts one cycle after commit.
    // -----------------------------------------------------------------------
    always_comb begin
        tmr_en    = regs_q[IDX_CTRL][0];
        tmr_auto  = regs_q[IDX_CTRL][1];
        count_d   = count_q;
        irq_d     = 1'b0;
        en_prev_d = tmr_en;

        if (tmr_en) begin
            if (!en_prev_q) begin
                count_d = regs_q[IDX_LOAD];
            end else if (count_q != '0) begin
                count_d = count_q - ONE;
                irq_d   = (count_q == ONE);
            end else if (tmr_auto) begin
                count_d = regs_q[IDX_LOAD];
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            // NOTE: the register file is built from flops, not a RAM, so it is
            // reset along with the rest of the state and reads 0 afterwards.
            regs_q     <= '0;
            aw_flag_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_flag_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            count_q    <= '0;
            irq_q      <= 1'b0;
            en_prev_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge value of every other flop regardless of order.
            regs_q     <= regs_d;
            aw_flag_q  <= aw_flag_d;
            aw_idx_q   <= aw_idx_d;
            w_flag_q   <= w_flag_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            count_q    <= count_d;
            irq_q      <= irq_d;
            en_prev_q  <= en_prev_d;
        end
    end

endmodule

// File: tb/tb_adap_timer_axil_slave.sv
// ---------------------------------------------------------------------------
// tb_adap_timer_axil_slave
//
// Drives AXI4-Lite transactions into adap_timer_axil_slave and checks every
// output on every falling clock edge against a transaction-level model of the
// register file, the two channels and the timer. Directed scenarios add
// hand-computed literal expectations; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_adap_timer_axil_slave;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;

    logic [3:0]  awaddr  = '0;
    logic [2:0]  awprot  = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata   = '0;
    logic [3:0]  wstrb   = '0;
    logic        wvalid  = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready  = 1'b0;
    logic [3:0]  araddr  = '0;
    logic [2:0]  arprot  = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready  = 1'b0;
    logic [31:0] timer_count;
    logic        timer_irq;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit cmp_en       = 1'b0;

    always #5 clk = ~clk;

    adap_timer_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .timer_count   (timer_count),
        .timer_irq     (timer_irq)
    );

    // -----------------------------------------------------------------------
    // Checking helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int waited);
        n_compared++;
        n_mismatched++;
        $display("FAIL %s: no response after %0d cycles, expected one within the bound", name, waited);
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: one state snapshot per clock, advanced by applying
    // the register-map, channel and timer rules to the pre-edge snapshot.
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [3:0][31:0] regs;
        logic             aw_pend;
        logic [1:0]       aw_idx;
        logic             w_pend;
        logic [31:0]      wdata;
        logic [3:0]       wstrb;
        logic             bvalid;
        logic             rvalid;
        logic [31:0]      rdata;
        logic [31:0]      count;
        logic             irq;
        logic             en_prev;
    } model_t;

    model_t m;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic model_t model_next(input model_t s);
        model_t n;
        n     = s;
        n.irq = 1'b0;

        // Timer, from the registers as they stood before this edge.
        if (s.regs[1][0]) begin
            if (!s.en_prev) begin
                n.count = s.regs[0];
            end else if (s.count > 0) begin
                n.count = s.count - 1;
                n.irq   = (n.count == 0);
            end else if (s.regs[1][1]) begin
                n.count = s.regs[0];
            end
        end
        n.en_prev = s.regs[1][0];

        // Read: one outstanding transaction, data taken from the old registers.
        if (s.rvalid) begin
            if (rready) n.rvalid = 1'b0;
        end else if (arvalid) begin
            n.rvalid = 1'b1;
            n.rdata  = s.regs[araddr[3:2]];
        end

        // Write: collect the two halves, commit once both are held.
        if (s.bvalid && bready) n.bvalid = 1'b0;
        if (awvalid && !s.aw_pend && !s.bvalid) begin
            n.aw_pend = 1'b1;
            n.aw_idx  = awaddr[3:2];
        end
        if (wvalid && !s.w_pend && !s.bvalid) begin
            n.w_pend = 1'b1;
            n.wdata  = wdata;
            n.wstrb  = wstrb;
        end
        if (n.aw_pend && n.w_pend) begin
            n.regs[n.aw_idx] = merge(s.regs[n.aw_idx], n.wdata, n.wstrb);
            n.aw_pend        = 1'b0;
            n.w_pend         = 1'b0;
            n.bvalid         = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m);
    end

    // Single compare process: every output, every cycle it means something.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("awready", 32'(awready), 32'(!m.aw_pend && !m.bvalid));
            check("wready",  32'(wready),  32'(!m.w_pend && !m.bvalid));
            check("bvalid",  32'(bvalid),  32'(m.bvalid));
            check("arready", 32'(arready), 32'(!m.rvalid));
            check("rvalid",  32'(rvalid),  32'(m.rvalid));
            check("count",   timer_count,  m.count);
            check("irq",     32'(timer_irq), 32'(m.irq));
            if (m.bvalid) check("bresp", 32'(bresp), 32'd0);
            if (m.rvalid) begin
                check("rdata", rdata, m.rdata);
                check("rresp", 32'(rresp), 32'd0);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bus tasks: called on a falling edge, return on a falling edge.
    // -----------------------------------------------------------------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay, input int w_delay,
                             input int b_delay, output int b_held, output logic [1:0] resp);
        int cyc = 0;
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        b_held = 0;
        resp   = 2'b11;
        awaddr = addr;
        awprot = 3'($urandom);
        wdata  = data;
        wstrb  = strb;
        while (!(aw_done && w_done) && cyc <= 100) begin
            if (!aw_done && cyc >= aw_delay) awvalid = 1'b1;
            if (!w_done  && cyc >= w_delay)  wvalid  = 1'b1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid  && wready;
            @(negedge clk);
            cyc++;
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
        end
        if (!(aw_done && w_done)) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            timeout("write_addr_data", cyc);
            return;
        end
        cyc = 0;
        while (!bvalid && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bvalid) begin
            timeout("write_resp", cyc);
            return;
        end
        for (int i = 0; i < b_delay; i++) begin
            if (bvalid) b_held++;
            @(negedge clk);
        end
        resp   = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_delay,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        data    = '1;
        resp    = 2'b11;
        araddr  = addr;
        arprot  = 3'($urandom);
        arvalid = 1'b1;
        while (!arready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!arready) begin
            arvalid = 1'b0;
            timeout("read_addr", cyc);
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 50) begin @(negedge clk); cyc++; end
        if (!rvalid) begin
            timeout("read_data", cyc);
            return;
        end
        repeat (r_delay) @(negedge clk);
        data   = rdata;
        resp   = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wait_count(input logic [31:0] v);
        int cyc = 0;
        while (timer_count !== v && cyc < 100) begin @(negedge clk); cyc++; end
        if (timer_count !== v) timeout("wait_count", cyc);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [31:0] wr_vals [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    logic [31:0] seq_ar  [6] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd4};
    logic [31:0] seq_one [6] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    logic        seq_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;
        int          held;
        int          irq_cnt;
        int          op, idx, rd_idx;
        logic [31:0] data;
        logic [3:0]  strb;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_count",  timer_count, 32'd0);
        check("rst_irq",    32'(timer_irq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready),  32'd1);
        check("rst_arready", 32'(arready), 32'd1);

        // Write all four registers, read each back
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(4 * i), wr_vals[i], 4'hF, 0, 0, 0, held, br);
            check("bresp_okay", 32'(br), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(4 * i), 0, rd, rr);
            check("readback", rd, wr_vals[i]);
            check("rresp_okay", 32'(rr), 32'd0);
        end

        // Byte strobes
        axi_write(4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0, held, br);
        axi_write(4'h8, 32'h12345678, 4'h3, 0, 0, 0, held, br);
        check("model_strobe", m.regs[2], 32'hFFFF5678);
        axi_read(4'h8, 0, rd, rr);
        check("strobe_read", rd, 32'hFFFF5678);

        // AW three cycles ahead of W, BREADY held off five cycles
        axi_write(4'hC, 32'h5a5aa5a5, 4'hF, 0, 3, 5, held, br);
        check("bvalid_held", 32'(held), 32'd5);
        axi_read(4'hC, 0, rd, rr);
        check("skew_read", rd, 32'h5a5aa5a5);

        // Timer with auto-reload: period LOAD+1
        axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0, held, br);
        axi_write(4'h0, 32'd4, 4'hF, 0, 0, 0, held, br);
        axi_write(4'h4, 32'd3, 4'hF, 0, 0, 0, held, br);
        wait_count(32'd4);
        for (int i = 0; i < 6; i++) begin
            check("seq_auto_count", timer_count, seq_ar[i]);
            check("seq_auto_irq",   32'(timer_irq), 32'(seq_irq[i]));
            check("model_seq_auto", m.count, seq_ar[i]);
            @(negedge clk);
        end
        irq_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (timer_irq) irq_cnt++;
            @(negedge clk);
        end
        check("irq_every_5", 32'(irq_cnt), 32'd4);

        // Timer one-shot: single pulse, then hold 0
        axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0, held, br);
        axi_write(4'h4, 32'h1, 4'hF, 0, 0, 0, held, br);
        wait_count(32'd4);
        for (int i = 0; i < 6; i++) begin
            check("seq_once_count", timer_count, seq_one[i]);
            check("seq_once_irq",   32'(timer_irq), 32'(seq_irq[i]));
            @(negedge clk);
        end
        irq_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (timer_irq || timer_count != 0) irq_cnt++;
            @(negedge clk);
        end
        check("once_holds_zero", 32'(irq_cnt), 32'd0);

        // Read stalled by RREADY while a write changes the same register
        axi_write(4'h8, 32'h11111111, 4'hF, 0, 0, 0, held, br);
        fork
            axi_read(4'h8, 4, rd, rr);
            axi_write(4'h8, 32'h22222222, 4'hF, 0, 0, 0, held, br);
        join
        check("read_old_value", rd, 32'h11111111);
        axi_read(4'h8, 0, rd, rr);
        check("read_new_value", rd, 32'h22222222);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            op     = int'($urandom_range(0, 2));
            idx    = int'($urandom_range(0, 3));
            rd_idx = int'($urandom_range(0, 3));
            data   = (idx == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            strb   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (op)
                0: axi_write({2'(idx), 2'($urandom)}, data, strb,
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)), held, br);
                1: axi_read({2'(rd_idx), 2'($urandom)}, int'($urandom_range(0, 3)), rd, rr);
                default: fork
                    axi_read({2'(rd_idx), 2'($urandom)}, int'($urandom_range(0, 3)), rd, rr);
                    axi_write({2'(idx), 2'($urandom)}, data, strb,
                              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                              int'($urandom_range(0, 2)), held, br);
                join
            endcase
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        // Reset in the middle of a write response with the counter at 2
        axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0, held, br);
        axi_write(4'h0, 32'd20, 4'hF, 0, 0, 0, held, br);
        axi_write(4'h4, 32'h1, 4'hF, 0, 0, 0, held, br);
        awaddr  = 4'hC;
        wdata   = 32'hcafef00d;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_count(32'd2);
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        check("pre_rst_count",  timer_count, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bvalid", 32'(bvalid), 32'd0);
        check("async_rst_rvalid", 32'(rvalid), 32'd0);
        check("async_rst_count",  timer_count, 32'd0);
        check("async_rst_irq",    32'(timer_irq), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_wready",  32'(wready),  32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(4 * i), 0, rd, rr);
            check("post_rst_reg", rd, 32'd0);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Global guard against a hung handshake
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
